// File: rtl/ext_out_port_if.sv
// Bundle between the datapath output-write side and the external consumer.
// The slave modport is the port's view; master is the driver/consumer view.
interface ext_out_port_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CountWidth = $clog2(DEPTH) + 1;

    logic                  out_write;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] ext_out;
    logic                  ext_valid;
    logic                  ext_ready;
    logic [CountWidth-1:0] count;
    logic                  overflow;

    modport slave (
        input  out_write,
        input  data_in,
        input  ext_ready,
        output out_full,
        output ext_out,
        output ext_valid,
        output count,
        output overflow
    );

    modport master (
        output out_write,
        output data_in,
        output ext_ready,
        input  out_full,
        input  ext_out,
        input  ext_valid,
        input  count,
        input  overflow
    );
endinterface

// File: rtl/ext_out_port.sv
// Datapath output port: buffers written words in a small circular FIFO and
// presents them to an external consumer over a valid/ready handshake.
module ext_out_port #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input logic           clk,
    input logic           rst_n,
    ext_out_port_if.slave port_io
);
    localparam int unsigned PtrWidth   = $clog2(DEPTH);
    localparam int unsigned CountWidth = PtrWidth + 1;
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic full;
    logic valid;
    logic push;
    logic pop;

    assign full  = (count_q == FullCount);
    assign valid = (count_q != '0);
    // Fullness is judged on the current count, so a pop in the same cycle
    // does not make room for a write.
    assign push  = port_io.out_write && !full;
    assign pop   = valid && port_io.ext_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (port_io.out_write && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= port_io.data_in;
        end
    end

    assign port_io.out_full  = full;
    assign port_io.ext_valid = valid;
    assign port_io.ext_out   = valid ? mem_q[rd_ptr_q] : '0;
    assign port_io.count     = count_q;
    assign port_io.overflow  = overflow_q;
endmodule

// File: tb/tb_ext_out_port.sv
// Directed self-checking bench for ext_out_port.
module tb_ext_out_port;
    localparam int unsigned DW = 16;
    localparam int unsigned DP = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ext_out_port_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    ext_out_port #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .port_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 32'(bus.ext_valid), 32'd0);
        chk({tag, ".out"},   32'(bus.ext_out),   32'd0);
        chk({tag, ".count"}, 32'(bus.count),     32'd0);
    endtask

    // Called at posedge+1; asserts and releases reset between edges.
    task automatic do_reset();
        bus.out_write = 1'b0;
        bus.ext_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_empty("async_rst");
        chk("async_rst.ovf",  32'(bus.overflow), 32'd0);
        chk("async_rst.full", 32'(bus.out_full), 32'd0);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        bus.out_write = 1'b1;
        bus.data_in   = w;
        tick();
        bus.out_write = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [DW-1:0] w);
        chk(tag, 32'(bus.ext_out), 32'(w));
        bus.ext_ready = 1'b1;
        tick();
        bus.ext_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.out_write = 1'b0;
        bus.data_in   = '0;
        bus.ext_ready = 1'b0;
        #1;
        chk_empty("reset");
        chk("reset.full", 32'(bus.out_full), 32'd0);
        chk("reset.ovf",  32'(bus.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word, one-cycle latency, then pop back to empty
        push_word(16'h0049);
        chk("single.valid", 32'(bus.ext_valid), 32'd1);
        chk("single.out",   32'(bus.ext_out),   32'h0049);
        chk("single.count", 32'(bus.count),     32'd1);
        pop_expect("single.pop", 16'h0049);
        chk_empty("single.after");

        // Fill, overflow, drain in order
        push_word(16'h0049);
        push_word(16'hFF49);
        push_word(16'h0064);
        push_word(16'h0000);
        chk("fill.count", 32'(bus.count),    32'd4);
        chk("fill.full",  32'(bus.out_full), 32'd1);
        chk("fill.out",   32'(bus.ext_out),  32'h0049);
        chk("fill.ovf0",  32'(bus.overflow), 32'd0);
        push_word(16'h1234);
        chk("ovf.flag",  32'(bus.overflow), 32'd1);
        chk("ovf.count", 32'(bus.count),    32'd4);
        chk("ovf.out",   32'(bus.ext_out),  32'h0049);
        tick();
        chk("hold.out", 32'(bus.ext_out), 32'h0049);
        pop_expect("drain0", 16'h0049);
        pop_expect("drain1", 16'hFF49);
        pop_expect("drain2", 16'h0064);
        pop_expect("drain3", 16'h0000);
        chk_empty("drain.end");
        chk("drain.ovf_sticky", 32'(bus.overflow), 32'd1);

        // Full with simultaneous write and pop: write dropped
        do_reset();
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        push_word(16'h0004);
        bus.out_write = 1'b1;
        bus.data_in   = 16'hAAAA;
        bus.ext_ready = 1'b1;
        tick();
        bus.out_write = 1'b0;
        bus.ext_ready = 1'b0;
        chk("fullrw.count", 32'(bus.count),    32'd3);
        chk("fullrw.ovf",   32'(bus.overflow), 32'd1);
        chk("fullrw.full",  32'(bus.out_full), 32'd0);
        pop_expect("fullrw.d0", 16'h0002);
        pop_expect("fullrw.d1", 16'h0003);
        pop_expect("fullrw.d2", 16'h0004);
        chk_empty("fullrw.end");

        // Count=2, simultaneous push and pop
        push_word(16'h0011);
        push_word(16'h0022);
        bus.out_write = 1'b1;
        bus.data_in   = 16'h0064;
        bus.ext_ready = 1'b1;
        tick();
        bus.out_write = 1'b0;
        bus.ext_ready = 1'b0;
        chk("pp.count", 32'(bus.count), 32'd2);
        pop_expect("pp.d0", 16'h0022);
        pop_expect("pp.d1", 16'h0064);
        chk_empty("pp.end");

        // Streaming with ready held: pointers wrap, occupancy stays at one
        do_reset();
        bus.ext_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.out_write = 1'b1;
            bus.data_in   = DW'(i);
            tick();
            chk($sformatf("stream%0d.out", i), 32'(bus.ext_out), 32'(i));
            chk($sformatf("stream%0d.cnt", i), 32'(bus.count), 32'd1);
            chk($sformatf("stream%0d.flags", i), {30'd0, bus.out_full, bus.overflow}, 32'd0);
        end
        bus.out_write = 1'b0;
        tick();
        bus.ext_ready = 1'b0;
        chk_empty("stream.end");

        // Async reset mid-cycle with count=3 and overflow set
        push_word(16'h0101);
        push_word(16'h0202);
        push_word(16'h0303);
        push_word(16'h0404);
        push_word(16'h0505);
        pop_expect("pre_rst.d0", 16'h0101);
        chk("pre_rst.count", 32'(bus.count),    32'd3);
        chk("pre_rst.ovf",   32'(bus.overflow), 32'd1);
        do_reset();
        chk_empty("post_rst");
        push_word(16'h0049);
        chk("post_rst.out",   32'(bus.ext_out), 32'h0049);
        chk("post_rst.count", 32'(bus.count),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
